press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent input channels.
REQ-002 SHALL have parameter DEB_CYC, default 1000: consecutive stable clk cycles required to accept a level change.
REQ-003 SHALL have parameter LONG_CYC, default 100000: held cycles, counted from level rise, that classify a press as long.
REQ-004 SHALL derive counter widths as $clog2(DEB_CYC) and $clog2(LONG_CYC+1); no other width parameters are exposed.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in  input  CH  raw, asynchronous, bouncing inputs, one bit per channel.
REQ-008 level  output  CH  debounced registered level per channel.
REQ-009 press_short  output  CH  one-cycle pulse per completed press shorter than LONG_CYC.
REQ-010 press_long  output  CH  one-cycle pulse when a held press reaches LONG_CYC.

Function
REQ-011 Each channel SHALL pass in through a 2-flop synchronizer; only the second flop (sync) feeds the FSM.
REQ-012 Channels SHALL be fully independent; activity on one channel SHALL never affect another.
REQ-013 Per-channel FSM states SHALL be: IDLE, DEB_PRESS, HELD, LONG, DEB_REL.
REQ-014 IDLE: sync=1 -> DEB_PRESS, deb counter cleared to 0.
REQ-015 DEB_PRESS: sync=0 -> IDLE, no output change (glitch rejected); deb counter = DEB_CYC-1 with sync=1 -> HELD, level<=1, hold counter cleared.
REQ-016 level SHALL rise at the (DEB_CYC+2)th rising edge after the edge that first samples in=1, provided in stays high throughout.
REQ-017 HELD: hold counter increments each cycle; at LONG_CYC-1 with sync=1 -> LONG with press_long=1 for exactly one cycle (LONG_CYC cycles after level rises).
REQ-018 HELD or LONG: sync=0 -> DEB_REL, deb counter cleared; a long_flag SHALL record which state was left.
REQ-019 DEB_REL: hold counter frozen; sync=1 -> return to the recorded state (HELD or LONG), no pulse.
REQ-020 DEB_REL: deb counter = DEB_CYC-1 with sync=0 -> IDLE, level<=0; press_short=1 for one cycle on the same edge if long_flag=0.
REQ-021 press_short and press_long SHALL never both be asserted for the same press; each press yields exactly one pulse.
REQ-022 Hold counter SHALL saturate; a press held indefinitely produces no further press_long pulses.
REQ-023 All outputs SHALL be registered; no combinational path from in to any output.

Reset
REQ-024 rst_n low SHALL asynchronously force all synchronizer flops, counters and long_flag to 0, all FSMs to IDLE, and level, press_short, press_long to 0.
REQ-025 Reset asserted mid-press SHALL discard the press; no pulse SHALL be emitted at or after deassertion for that press.
REQ-026 After deassertion with in held high, the channel SHALL run a full press debounce from IDLE.

Structure
REQ-027 Shared package press_classifier_pkg SHALL hold the FSM state encoding and default DEB_CYC and LONG_CYC constants.
REQ-028 One sub-module, press_channel (synchronizer, FSM, both counters), SHALL be instantiated CH times by a generate loop.

Verification (CH=2, DEB_CYC=4, LONG_CYC=16)
REQ-029 Reset: rst_n=0 with in=2'b11 -> level, press_short and press_long all 0; after deassertion, level[0] rises 6 edges later.
REQ-030 Glitch: in[0] high for 3 cycles -> level[0] stays 0, no pulses.
REQ-031 Short press: in[0] high 14 cycles, then low -> level[0]=1 for about 14 cycles; single press_short[0] pulse on the edge where level[0] falls; press_long[0] stays 0; channel 1 quiet.
REQ-032 Long press: in[1] high 30 cycles -> press_long[1] pulse exactly 16 cycles after level[1] rises; no press_short[1] on release; single pulse only.
REQ-033 Release bounce: during HELD, in[0] low 2 cycles then high -> level[0] stays 1, no pulse; final clean release -> one press_short[0].
REQ-034 Reset mid-press: rst_n pulsed low 1 cycle while channel 0 is in HELD -> outputs 0 immediately; with in[0] then low, no press_short[0] is ever emitted.

Source files
------------

// File: rtl/press_classifier_pkg.sv
// Shared state encoding and default timing constants for the press classifier.
package press_classifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_LONG,
    ST_DEB_REL
  } state_t;

  localparam int DEF_DEB_CYC  = 1000;
  localparam int DEF_LONG_CYC = 100000;

endpackage

// File: rtl/press_channel.sv
// One input channel: 2-flop synchronizer, debounce/hold FSM and its counters.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | released, level=0, waiting for sync to go high
//   ST_DEB_PRESS | sync high, counting DEB_CYC stable cycles before accepting
//   ST_HELD      | level=1, hold counter running toward LONG_CYC
//   ST_LONG      | level=1, long press already reported, hold counter saturated
//   ST_DEB_REL   | sync low, counting DEB_CYC stable cycles before releasing;
//                | long_flag remembers whether HELD or LONG was left
module press_channel
  import press_classifier_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic press_short,
  output logic press_long
);

  // A one-cycle debounce still needs a 1-bit counter to hold the compare value.
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW = $clog2(LONG_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYC);

  logic          sync_q1, sync;
  state_t        state, state_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          long_flag, flag_n;
  logic          level_n, short_n, long_n;

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1     <= 1'b0;
      sync        <= 1'b0;
      state       <= ST_IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      long_flag   <= 1'b0;
      level       <= 1'b0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
    end else begin
      sync_q1     <= in;
      sync        <= sync_q1;
      state       <= state_n;
      deb_cnt     <= deb_n;
      hold_cnt    <= hold_n;
      long_flag   <= flag_n;
      level       <= level_n;
      press_short <= short_n;
      press_long  <= long_n;
    end
  end

  // Next-state, counter and output decisions from the synchronized input.
  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    hold_n  = hold_cnt;
    flag_n  = long_flag;
    level_n = level;
    short_n = 1'b0;
    long_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_n = ST_DEB_PRESS;
          deb_n   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!sync) begin
          state_n = ST_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = ST_HELD;
          level_n = 1'b1;
          hold_n  = '0;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_n = ST_DEB_REL;
          deb_n   = '0;
          flag_n  = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = ST_LONG;
          long_n  = 1'b1;
          hold_n  = HOLD_SAT;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (!sync) begin
          state_n = ST_DEB_REL;
          deb_n   = '0;
          flag_n  = 1'b1;
        end
      end
      ST_DEB_REL: begin
        // A bounce back high resumes the press where it left off, hold count intact.
        if (sync) begin
          state_n = long_flag ? ST_LONG : ST_HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = ST_IDLE;
          level_n = 1'b0;
          short_n = ~long_flag;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/press_classifier.sv
// Multi-channel press classifier: CH independent debounced short/long press detectors.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int CH       = 4,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press_short,
  output logic [CH-1:0] press_long
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    press_channel #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (in[g]),
      .level       (level[g]),
      .press_short (press_short[g]),
      .press_long  (press_long[g])
    );
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with a cycle-level behavioural reference.
module tb_press_classifier;

  localparam int CH       = 2;
  localparam int DEB_CYC  = 4;
  localparam int LONG_CYC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in;
  logic [CH-1:0] level, press_short, press_long;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  press_classifier #(
    .CH       (CH),
    .DEB_CYC  (DEB_CYC),
    .LONG_CYC (LONG_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .level       (level),
    .press_short (press_short),
    .press_long  (press_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a level flips once the synchronized input has disagreed with
  // it on DEB_CYC+1 consecutive edges; a press is long once it has accumulated
  // LONG_CYC edges of uninterrupted-high sampling after the level rose.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_done = '0;
  logic [CH-1:0] m_level = '0, m_short = '0, m_long = '0;
  int            m_run [CH];
  int            m_hold[CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_done = '0;
      m_level = '0; m_short = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_short[c] = 1'b0;
        m_long[c]  = 1'b0;
        if (m_level[c] && m_s2[c] && m_prev[c] && !m_done[c]) begin
          m_hold[c]++;
          if (m_hold[c] == LONG_CYC) begin
            m_long[c] = 1'b1;
            m_done[c] = 1'b1;
          end
        end
        m_run[c] = (m_s2[c] != m_level[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DEB_CYC + 1) begin
          m_run[c]   = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            m_hold[c] = 0;
          end else begin
            m_short[c] = ~m_done[c];
            m_done[c]  = 1'b0;
          end
        end
        m_prev[c] = m_s2[c];
      end
      m_s2 = m_s1;
      m_s1 = in;
    end
  end

  // Event log of the DUT outputs, used by the hand-computed timing checks.
  int cnt_rise[CH], cnt_fall[CH], cnt_short[CH], cnt_long[CH];
  int last_rise[CH], last_fall[CH], last_short[CH], last_long[CH];
  logic [CH-1:0] prev_level = '0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      cnt_rise[c] = 0; cnt_fall[c] = 0; cnt_short[c] = 0; cnt_long[c] = 0;
      last_rise[c] = -1; last_fall[c] = -1; last_short[c] = -1; last_long[c] = -1;
    end
  end

  // Compare DUT against the model every cycle, then log output events.
  always @(negedge clk) begin
    chk("level", int'(level), int'(m_level));
    chk("press_short", int'(press_short), int'(m_short));
    chk("press_long", int'(press_long), int'(m_long));
    chk("one_pulse_kind", int'(press_short & press_long), 0);
    for (int c = 0; c < CH; c++) begin
      if (level[c] && !prev_level[c]) begin cnt_rise[c]++; last_rise[c] = cyc; end
      if (!level[c] && prev_level[c]) begin cnt_fall[c]++; last_fall[c] = cyc; end
      if (press_short[c]) begin cnt_short[c]++; last_short[c] = cyc; end
      if (press_long[c])  begin cnt_long[c]++;  last_long[c]  = cyc; end
    end
    prev_level = level;
  end

  int e0, r0, f0, s0, l0, s1, l1, r1;

  task automatic snap();
    r0 = cnt_rise[0]; f0 = cnt_fall[0]; s0 = cnt_short[0]; l0 = cnt_long[0];
    r1 = cnt_rise[1]; s1 = cnt_short[1]; l1 = cnt_long[1];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 2'b11;
    wait_cyc(3);
    chk("rst_level", int'(level), 0);
    chk("rst_short", int'(press_short), 0);
    chk("rst_long", int'(press_long), 0);
    rst_n = 1'b1;
    e0 = cyc + 1;
    wait_cyc(9);
    chk("rst_rise_dly0", last_rise[0] - e0, 6);
    chk("rst_rise_dly1", last_rise[1] - e0, 6);
    in = 2'b00;
    wait_cyc(12);

    // glitch shorter than the debounce window
    snap();
    in[0] = 1'b1;
    wait_cyc(3);
    in[0] = 1'b0;
    wait_cyc(12);
    chk("glitch_rise", cnt_rise[0] - r0, 0);
    chk("glitch_short", cnt_short[0] - s0, 0);

    // short press on channel 0
    snap();
    in[0] = 1'b1;
    wait_cyc(14);
    in[0] = 1'b0;
    wait_cyc(12);
    chk("short_cnt", cnt_short[0] - s0, 1);
    chk("short_nolong", cnt_long[0] - l0, 0);
    chk("short_width", last_fall[0] - last_rise[0], 14);
    chk("short_at_fall", last_short[0] - last_fall[0], 0);
    chk("short_ch1_quiet", (cnt_short[1] - s1) + (cnt_long[1] - l1) + (cnt_rise[1] - r1), 0);

    // long press on channel 1
    snap();
    in[1] = 1'b1;
    wait_cyc(30);
    in[1] = 1'b0;
    wait_cyc(12);
    chk("long_cnt", cnt_long[1] - l1, 1);
    chk("long_noshort", cnt_short[1] - s1, 0);
    chk("long_delay", last_long[1] - last_rise[1], 16);

    // release bounce during HELD
    snap();
    in[0] = 1'b1;
    wait_cyc(12);
    in[0] = 1'b0;
    wait_cyc(2);
    in[0] = 1'b1;
    wait_cyc(6);
    in[0] = 1'b0;
    wait_cyc(12);
    chk("bounce_rise", cnt_rise[0] - r0, 1);
    chk("bounce_fall", cnt_fall[0] - f0, 1);
    chk("bounce_short", cnt_short[0] - s0, 1);

    // reset while channel 0 is held
    snap();
    in[0] = 1'b1;
    wait_cyc(10);
    chk("mid_level_up", int'(level[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_pulses", int'(press_short | press_long), 0);
    wait_cyc(1);
    rst_n = 1'b1;
    in[0] = 1'b0;
    wait_cyc(20);
    chk("mid_no_short", cnt_short[0] - s0, 0);
    chk("mid_no_long", cnt_long[0] - l0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
